// File: rtl/lshift_pkg.sv
// Shared types and default sizes for the rotate-sequence controller and its
// rotate-register core.
package lshift_pkg;

  localparam int LSHIFT_WIDTH = 8;
  localparam int LSHIFT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lshift_seq_ctrl_if.sv
// Command/result bundle between a requester (master) and the rotate-sequence
// controller (slave).
interface lshift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready never depends on cmd_valid. A requester may keep cmd_valid high;
  // the controller takes the next command only after the current one's done cycle.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_val;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_val, cmd_count, abort,
    input  cmd_ready, busy, data_out, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_val, cmd_count, abort,
    output cmd_ready, busy, data_out, done, aborted
  );

endinterface

// File: rtl/lshift_core.sv
// Rotate register: loads a value or rotates it left by one bit per enabled edge.
// Load wins over rotate if both are asserted.
module lshift_core #(
  parameter int WIDTH = lshift_pkg::LSHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             rot_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] op
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_val;
    end else if (rot_en) begin
      data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign op = data_q;

endmodule

// File: rtl/lshift_seq_ctrl.sv
// Rotate-sequence controller: accepts a (value, count) command, loads the
// rotate register, rotates it count times (abortable) and pulses done.
module lshift_seq_ctrl
  import lshift_pkg::*;
#(
  parameter int WIDTH = LSHIFT_WIDTH,
  parameter int CNT_W = LSHIFT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  lshift_seq_ctrl_if.slave   bus,
  output state_e             state_dbg
);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] val_q,     val_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             aborted_q, aborted_d;
  logic             load_en;
  logic             rot_en;

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    load_en   = 1'b0;
    rot_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          val_d     = bus.cmd_val;
          cnt_d     = bus.cmd_count;
          aborted_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        // Abort stops before this edge's rotation so data_out keeps the partial result.
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          rot_en = 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        aborted_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      val_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  lshift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .rot_en   (rot_en),
    .load_val (val_q),
    .op       (bus.data_out)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.aborted   = (state_q == ST_DONE) && aborted_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_lshift_seq_ctrl.sv
// Bench for lshift_seq_ctrl: directed cases plus random commands checked
// against an arithmetic rotate/latency model.
module tb_lshift_seq_ctrl;
  import lshift_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic   clk;
  logic   rst;
  state_e state_dbg;
  int     n_checks;
  int     n_errors;
  logic [W-1:0] exp_q[$];

  lshift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bif ();

  lshift_seq_ctrl #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: left rotation by k positions, wrapping modulo W.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int k);
    int s;
    int x;
    s = k % W;
    x = int'(v);
    return W'(((x << s) | (x >> (W - s))) & ((1 << W) - 1));
  endfunction

  // Called at #1 after the accepting edge. Counts edges until done and checks
  // latency, result and flags. abort_edge is the edge index (1-based after
  // accept) whose sample of abort is high; 0 means never.
  task automatic wait_done(input string tag, input int exp_lat, input logic exp_ab,
                           input int abort_edge, input bit hold);
    int n;
    int got_lat;
    logic [W-1:0] exp_v;
    got_lat = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      bif.abort = (n == abort_edge);
      if (n == 1 && !hold) begin
        bif.cmd_valid = 1'b0;
        bif.cmd_val   = W'($urandom_range(0, 255));
        bif.cmd_count = CW'($urandom_range(0, 15));
      end
      @(posedge clk);
      #1;
      if (bif.done) begin
        got_lat = n;
        break;
      end
      check({tag, "_busy"}, bif.busy, 1'b1);
      check({tag, "_ready_busy"}, bif.cmd_ready, 1'b0);
    end
    bif.abort = 1'b0;
    if (got_lat == 0) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    exp_v = exp_q.pop_front();
    check({tag, "_latency"}, got_lat, exp_lat);
    check({tag, "_data"}, bif.data_out, exp_v);
    check({tag, "_aborted"}, bif.aborted, exp_ab);
    check({tag, "_ready_done"}, bif.cmd_ready, 1'b0);
    check({tag, "_busy_done"}, bif.busy, 1'b0);
    // Abort during DONE must be ignored.
    bif.abort = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bif.abort = 1'b0;
    check({tag, "_done_pulse"}, bif.done, 1'b0);
    check({tag, "_aborted_clr"}, bif.aborted, 1'b0);
    check({tag, "_data_hold"}, bif.data_out, exp_v);
    check({tag, "_ready_idle"}, bif.cmd_ready, 1'b1);
  endtask

  // Driver: issue one command; abort_k < 0 means run to completion.
  task automatic run_cmd(input string tag, input logic [W-1:0] val, input int cnt,
                         input int abort_k, input bit abort_in_load);
    int lat;
    int aedge;
    @(negedge clk);
    check({tag, "_ready_pre"}, bif.cmd_ready, 1'b1);
    bif.cmd_valid = 1'b1;
    bif.cmd_val   = val;
    bif.cmd_count = CW'(cnt);
    if (abort_k >= 0) begin
      exp_q.push_back(rotl(val, abort_k));
      lat   = abort_k + 2;
      aedge = abort_k + 2;
    end else begin
      exp_q.push_back(rotl(val, cnt));
      lat   = cnt + 1;
      aedge = abort_in_load ? 1 : 0;
    end
    @(posedge clk);
    #1;
    wait_done(tag, lat, abort_k >= 0, aedge, 1'b0);
  endtask

  initial begin
    int seen_done;
    int cnt;
    int k;
    n_checks = 0;
    n_errors = 0;
    rst           = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd_val   = '0;
    bif.cmd_count = '0;
    bif.abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_low", bif.cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_data", bif.data_out, 0);
    check("reset_ready", bif.cmd_ready, 1'b1);
    check("reset_busy", bif.busy, 1'b0);
    check("reset_done", bif.done, 1'b0);
    check("reset_aborted", bif.aborted, 1'b0);
    check("reset_state", state_dbg, ST_IDLE);

    // Directed cases
    run_cmd("c81_1", 8'h81, 1, -1, 1'b1);
    run_cmd("ca5_0", 8'hA5, 0, -1, 1'b0);
    run_cmd("c3c_8", 8'h3C, 8, -1, 1'b0);
    run_cmd("c01_15", 8'h01, 15, -1, 1'b0);
    run_cmd("abort3", 8'h01, 10, 3, 1'b0);
    run_cmd("abort0", 8'hC3, 5, 0, 1'b0);

    // Back-to-back with cmd_valid held high
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_val   = 8'h81;
    bif.cmd_count = 4'd1;
    exp_q.push_back(8'h03);
    @(posedge clk);
    #1;
    bif.cmd_val   = 8'h01;
    bif.cmd_count = 4'd15;
    wait_done("b2b_first", 2, 1'b0, 0, 1'b1);
    exp_q.push_back(8'h80);
    @(posedge clk);
    #1;
    check("b2b_accept", bif.cmd_ready, 1'b0);
    check("b2b_state", state_dbg, ST_LOAD);
    wait_done("b2b_second", 16, 1'b0, 0, 1'b0);

    // Random commands against the model
    for (int i = 0; i < 25; i++) begin
      cnt = $urandom_range(0, 15);
      k   = -1;
      if (cnt > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, cnt - 1);
      end
      run_cmd($sformatf("rnd%0d", i), W'($urandom_range(0, 255)), cnt, k,
              1'($urandom_range(0, 1)));
    end

    // Reset pulse mid-SHIFT
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_val   = 8'h01;
    bif.cmd_count = 4'd10;
    @(posedge clk);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_data", bif.data_out, 8'h04);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_data", bif.data_out, 0);
    check("rst_async_busy", bif.busy, 1'b0);
    check("rst_async_done", bif.done, 1'b0);
    check("rst_async_state", state_dbg, ST_IDLE);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bif.done) seen_done++;
    end
    check("rst_no_done", seen_done, 0);
    check("rst_ready_after", bif.cmd_ready, 1'b1);
    check("rst_data_after", bif.data_out, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lshift_seq_ctrl.md
LSHIFT_SEQ_CTRL -- requirements
Module: lshift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data width of the rotate register.
REQ-002 Parameter CNT_W, default 4, width of the rotate-count field (0..2^CNT_W-1 positions).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_valid  input  1  requester has a command.
REQ-006 cmd_ready  output  1  controller can accept a command this cycle.
REQ-007 cmd_val  input  WIDTH  value to load before rotating.
REQ-008 cmd_count  input  CNT_W  number of 1-bit left rotations to perform.
REQ-009 abort  input  1  stop an in-progress rotation early.
REQ-010 busy  output  1  command in progress (LOAD or SHIFT state).
REQ-011 data_out  output  WIDTH  current rotate-register contents.
REQ-012 done  output  1  one-cycle pulse; data_out holds the final result.
REQ-013 aborted  output  1  valid with done; 1 when the command ended by abort.

Function
REQ-014 The controller SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-016 On acceptance the controller SHALL capture cmd_val and cmd_count into holding registers and move to LOAD.
REQ-017 In LOAD the next edge SHALL load the captured value into the rotate register and move to SHIFT if count>0, else to DONE.
REQ-018 In SHIFT each edge SHALL rotate left by one, data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]}, and decrement the remaining count; the edge performing the last rotation moves to DONE.
REQ-019 done SHALL be asserted exactly count+1 rising edges after the accepting edge, for one cycle, then the state returns to IDLE.
REQ-020 Rotation SHALL wrap modulo WIDTH; count=WIDTH returns the loaded value unchanged.
REQ-021 abort sampled high in SHIFT SHALL move to DONE on that edge without rotating, aborted=1, data_out holding the partial result.
REQ-022 abort in IDLE, LOAD or DONE SHALL be ignored; aborted SHALL be 0 when done is 0.
REQ-023 cmd_val/cmd_count changes while busy SHALL have no effect; no command is accepted in DONE.
REQ-024 data_out SHALL hold its value in IDLE and DONE.

Reset
REQ-025 rst high SHALL immediately force state IDLE, data_out=0, done=0, aborted=0, busy=0, holding registers=0; cmd_ready=1 while rst is low and state is IDLE.
REQ-026 rst asserted mid-command SHALL discard the command with no done pulse.
REQ-027 rst SHALL take priority over every other input on the same edge.

Structure
REQ-028 Package lshift_pkg SHALL hold the state enum type and default WIDTH and CNT_W constants.
REQ-029 The rotate register SHALL be a sub-module lshift_core (load_en, rot_en, load_val, op; rising-edge, async active-high reset) instanced by the controller.
REQ-030 The FSM, count register and handshake SHALL live in lshift_seq_ctrl.

Verification
REQ-031 cmd_val=0x81, count=1 -> done 2 edges after accept, data_out=0x03, aborted=0.
REQ-032 cmd_val=0xA5, count=0 -> done 1 edge after accept, data_out=0xA5.
REQ-033 cmd_val=0x3C, count=8 -> done 9 edges after accept, data_out=0x3C; cmd_val=0x01, count=15 -> data_out=0x80.
REQ-034 cmd_val=0x01, count=10, abort after 3 rotations -> done next cycle, data_out=0x08, aborted=1.
REQ-035 cmd_valid held high through two back-to-back commands -> second accepted only in IDLE after first done; cmd_ready=0 throughout busy and DONE.
REQ-036 rst pulse during SHIFT -> data_out=0 asynchronously, no done pulse, cmd_ready=1 after release.
